// File: rtl/nucleo_batalha_pkg.sv
// Shared types for the naval-battle game core.
// States, shot result codes and display view codes.
package nucleo_batalha_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_EVAL,
    S_OVER
  } state_t;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_MISS   = 2'b01;
  localparam logic [1:0] RES_HIT    = 2'b10;
  localparam logic [1:0] RES_REPEAT = 2'b11;

  localparam logic [1:0] VIEW_BLANK   = 2'b00;
  localparam logic [1:0] VIEW_SHIPS   = 2'b01;
  localparam logic [1:0] VIEW_ATTACKS = 2'b10;
  localparam logic [1:0] VIEW_BOTH    = 2'b11;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/modulo_nucleo_batalha_varredura.sv
// Column scanner for the LED matrix.
// Prescaler plus column counter with a frame-wrap pulse.
module modulo_varredura_matriz
  import nucleo_batalha_pkg::*;
#(
  parameter int COLS     = 5,
  parameter int SCAN_DIV = 50000,
  localparam int CW = clog2_min1(COLS),
  localparam int PW = clog2_min1(SCAN_DIV)
) (
  input  logic            clk,
  input  logic            clr_n,
  output logic [CW-1:0]   col,
  output logic [COLS-1:0] m_col,
  output logic            frame_wrap
);

  logic [PW-1:0] pre;

  // Advance one column every SCAN_DIV cycles; flag the frame wrap.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pre        <= '0;
      col        <= '0;
      frame_wrap <= 1'b0;
    end else begin
      frame_wrap <= 1'b0;
      if (pre == PW'(SCAN_DIV - 1)) begin
        pre <= '0;
        if (col == CW'(COLS - 1)) begin
          col        <= '0;
          frame_wrap <= 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  // One-hot strobe for the active column.
  always_comb begin
    m_col = '0;
    for (int c = 0; c < COLS; c++)
      m_col[c] = (col == CW'(c));
  end

endmodule

// File: rtl/modulo_nucleo_batalha.sv
// Naval-battle game core: maps, cursor, shot evaluation.
// Also drives the column-scanned LED matrix.
module modulo_nucleo_batalha
  import nucleo_batalha_pkg::*;
#(
  parameter int ROWS      = 7,
  parameter int COLS      = 5,
  parameter int MAX_SHOTS = 20,
  parameter int SCAN_DIV  = 50000,
  localparam int N  = ROWS * COLS,
  localparam int RW = clog2_min1(ROWS),
  localparam int CW = clog2_min1(COLS),
  localparam int NW = clog2_min1(N + 1)
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic [N-1:0]    ship_map,
  input  logic            btn_next,
  input  logic            btn_fire,
  input  logic [1:0]      view_sel,
  output logic [RW-1:0]   cur_row,
  output logic [CW-1:0]   cur_col,
  output logic [NW-1:0]   hits,
  output logic [NW-1:0]   shots,
  output logic [1:0]      result,
  output logic            result_valid,
  output logic            game_over,
  output logic            win,
  output logic [COLS-1:0] m_col,
  output logic [ROWS-1:0] m_line
);

  state_t        state;
  logic [N-1:0]  ship_reg;
  logic [N-1:0]  attack_reg;
  logic [NW-1:0] ship_total;
  logic [NW-1:0] map_count;
  logic [N-1:0]  cur_mask;
  logic          ship_at;
  logic          att_at;
  logic          blink;
  logic          blink_on;
  logic [CW-1:0] scan_col;
  logic          frame_wrap;
  logic [ROWS-1:0] line_pix;
  logic          px;

  modulo_varredura_matriz #(
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .clr_n      (clr_n),
    .col        (scan_col),
    .m_col      (m_col),
    .frame_wrap (frame_wrap)
  );

  // Ship count of the map offered at load time.
  always_comb begin
    map_count = '0;
    for (int i = 0; i < N; i++)
      map_count = map_count + NW'(ship_map[i]);
  end

  // Cursor cell as a mask over the row-major map.
  always_comb begin
    cur_mask = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        cur_mask[r*COLS+c] = (cur_row == RW'(r)) &&
                             (cur_col == CW'(c));
  end

  assign ship_at = |(ship_reg & cur_mask);
  assign att_at  = |(attack_reg & cur_mask);

  // Game FSM with all outputs registered.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state        <= S_IDLE;
      ship_reg     <= '0;
      attack_reg   <= '0;
      ship_total   <= '0;
      cur_row      <= '0;
      cur_col      <= '0;
      hits         <= '0;
      shots        <= '0;
      result       <= RES_NONE;
      result_valid <= 1'b0;
      game_over    <= 1'b0;
      win          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (btn_fire) begin
            ship_reg   <= ship_map;
            ship_total <= map_count;
            if (map_count != '0)
              state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (btn_fire) begin
            // Shot is scored here so it is visible during S_EVAL.
            state        <= S_EVAL;
            result_valid <= 1'b1;
            if (att_at) begin
              result <= RES_REPEAT;
            end else begin
              attack_reg <= attack_reg | cur_mask;
              shots      <= shots + 1'b1;
              if (ship_at) begin
                hits   <= hits + 1'b1;
                result <= RES_HIT;
              end else begin
                result <= RES_MISS;
              end
            end
          end else if (btn_next) begin
            if (cur_row == RW'(ROWS - 1)) begin
              cur_row <= '0;
              if (cur_col == CW'(COLS - 1))
                cur_col <= '0;
              else
                cur_col <= cur_col + 1'b1;
            end else begin
              cur_row <= cur_row + 1'b1;
            end
          end
        end
        S_EVAL: begin
          if (hits == ship_total) begin
            state     <= S_OVER;
            game_over <= 1'b1;
            win       <= 1'b1;
          end else if (shots == NW'(MAX_SHOTS)) begin
            state     <= S_OVER;
            game_over <= 1'b1;
          end else begin
            state <= S_PLAY;
          end
        end
        S_OVER: begin
          if (btn_fire) begin
            state      <= S_IDLE;
            attack_reg <= '0;
            hits       <= '0;
            shots      <= '0;
            result     <= RES_NONE;
            win        <= 1'b0;
            game_over  <= 1'b0;
            cur_row    <= '0;
            cur_col    <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Cursor blink phase flips once per scan frame.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      blink <= 1'b0;
    else if (frame_wrap)
      blink <= ~blink;
  end

  assign blink_on = (state == S_PLAY) && view_sel[1] && blink;

  // Pixels of the strobed column, lines driven active-low.
  always_comb begin
    line_pix = '0;
    px       = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (scan_col == CW'(c)) begin
          px = (view_sel[0] & ship_reg[r*COLS+c]) |
               (view_sel[1] & attack_reg[r*COLS+c]);
          px = px ^ (blink_on & cur_mask[r*COLS+c]);
          line_pix[r] = px;
        end
      end
    end
  end

  assign m_line = ~line_pix;

endmodule

// File: tb/tb_modulo_nucleo_batalha.sv
// Directed bench for the naval-battle core.
// Shot results are scoreboarded against a small model.
module tb_modulo_nucleo_batalha;
  import nucleo_batalha_pkg::*;

  localparam int ROWS = 7;
  localparam int COLS = 5;
  localparam int MAXS = 4;
  localparam int SDIV = 2;
  localparam int N    = ROWS * COLS;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic [N-1:0]  ship_map = '0;
  logic          btn_next = 1'b0;
  logic          btn_fire = 1'b0;
  logic [1:0]    view_sel = 2'b00;
  logic [2:0]    cur_row;
  logic [2:0]    cur_col;
  logic [5:0]    hits;
  logic [5:0]    shots;
  logic [1:0]    result;
  logic          result_valid;
  logic          game_over;
  logic          win;
  logic [COLS-1:0] m_col;
  logic [ROWS-1:0] m_line;

  modulo_nucleo_batalha #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .MAX_SHOTS (MAXS),
    .SCAN_DIV  (SDIV)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .ship_map     (ship_map),
    .btn_next     (btn_next),
    .btn_fire     (btn_fire),
    .view_sel     (view_sel),
    .cur_row      (cur_row),
    .cur_col      (cur_col),
    .hits         (hits),
    .shots        (shots),
    .result       (result),
    .result_valid (result_valid),
    .game_over    (game_over),
    .win          (win),
    .m_col        (m_col),
    .m_line       (m_line)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] res;
    logic [5:0] h;
    logic [5:0] s;
    logic       go;
    logic       w;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  logic [N-1:0] m_ship;
  logic [N-1:0] m_atk;
  int mr, mc, mh, ms, mtot;
  bit in_play;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, 32'(cur_row), 32'(mr));
    check({tag, "_col"}, 32'(cur_col), 32'(mc));
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    if (in_play) begin
      mr++;
      if (mr == ROWS) begin
        mr = 0;
        mc++;
        if (mc == COLS) mc = 0;
      end
    end
  endtask

  task automatic load(input logic [N-1:0] v);
    ship_map = v;
    btn_fire = 1'b1;
    tick();
    btn_fire = 1'b0;
    m_ship = v;
    mtot = $countones(v);
    in_play = (mtot != 0);
  endtask

  task automatic restart();
    btn_fire = 1'b1;
    tick();
    btn_fire = 1'b0;
    m_atk = '0;
    mh = 0; ms = 0; mr = 0; mc = 0;
    in_play = 1'b0;
    check("rst_hits", 32'(hits), 0);
    check("rst_shots", 32'(shots), 0);
    check("rst_result", 32'(result), 32'(RES_NONE));
    check("rst_over", 32'(game_over), 0);
    check("rst_win", 32'(win), 0);
    check_cursor("rst_cur");
  endtask

  task automatic fire_shot(input bit with_next);
    exp_t e;
    int idx;
    int waited;
    idx = mr * COLS + mc;
    if (m_atk[idx]) begin
      e.res = RES_REPEAT;
    end else begin
      m_atk[idx] = 1'b1;
      ms++;
      if (m_ship[idx]) begin
        mh++;
        e.res = RES_HIT;
      end else begin
        e.res = RES_MISS;
      end
    end
    e.h  = 6'(mh);
    e.s  = 6'(ms);
    e.w  = (mh == mtot);
    e.go = (mh == mtot) || (ms == MAXS);
    sb.push_back(e);
    btn_fire = 1'b1;
    btn_next = with_next;
    tick();
    btn_fire = 1'b0;
    btn_next = 1'b0;
    waited = 0;
    while (!result_valid && waited < 4) begin
      tick();
      waited++;
    end
    e = sb.pop_front();
    if (result_valid) begin
      check("rv_latency", 32'(waited), 0);
      check("result", 32'(result), 32'(e.res));
      check("hits", 32'(hits), 32'(e.h));
      check("shots", 32'(shots), 32'(e.s));
      check("over_n1", 32'(game_over), 0);
      tick();
      check("rv_pulse", 32'(result_valid), 0);
      check("over_n2", 32'(game_over), 32'(e.go));
      check("win", 32'(win), 32'(e.w));
      check_cursor("shot_cur");
      if (e.go) in_play = 1'b0;
    end else begin
      check("rv_timeout", 0, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROWS-1:0] el;
    int guard;
    int kk;
    m_ship = '0; m_atk = '0;
    mr = 0; mc = 0; mh = 0; ms = 0; mtot = 0;
    in_play = 1'b0;

    #12;
    check("reset_hits", 32'(hits), 0);
    check("reset_shots", 32'(shots), 0);
    check("reset_result", 32'(result), 0);
    check("reset_rv", 32'(result_valid), 0);
    check("reset_over", 32'(game_over), 0);
    check("reset_win", 32'(win), 0);
    check("reset_mcol", 32'(m_col), 1);
    check("reset_mline", 32'(m_line), 32'h7f);
    check_cursor("reset_cur");
    clr_n = 1'b1;
    tick();

    load('0);
    for (int i = 0; i < 3; i++) begin
      check("idle_no_rv", 32'(result_valid), 0);
      tick();
    end
    press_next();
    check_cursor("idle_cur");

    load(N'(1) << 1 | N'(1) << 5 | N'(1) << 15);
    for (int i = 0; i < 35; i++) begin
      press_next();
      if (i == 6) begin
        check("cur7_row", 32'(cur_row), 0);
        check("cur7_col", 32'(cur_col), 1);
      end
    end
    check("cur35_row", 32'(cur_row), 0);
    check("cur35_col", 32'(cur_col), 0);

    press_next();
    fire_shot(1'b0);
    fire_shot(1'b0);
    press_next(); press_next();
    fire_shot(1'b0);
    press_next(); press_next();
    press_next(); press_next();
    check_cursor("last_ship");
    fire_shot(1'b0);
    check("win_final", 32'(win), 1);
    restart();

    load(N'(1) << 1 | N'(1) << 5 | N'(1) << 15);
    fire_shot(1'b0);
    press_next(); press_next();
    fire_shot(1'b0);
    press_next(); press_next();
    fire_shot(1'b0);
    press_next();
    fire_shot(1'b1);
    check("sim_cur_row", 32'(cur_row), 5);
    check("budget_over", 32'(game_over), 1);
    check("budget_win", 32'(win), 0);
    press_next();
    check_cursor("over_next");
    restart();

    view_sel = VIEW_SHIPS;
    guard = 0;
    while (m_col !== 5'b10000 && guard < 50) begin
      tick();
      guard++;
    end
    while (m_col !== 5'b00001 && guard < 50) begin
      tick();
      guard++;
    end
    check("scan_sync", 32'(guard < 50), 1);
    for (int k = 0; k < 6; k++) begin
      kk = k % COLS;
      for (int r = 0; r < ROWS; r++)
        el[r] = ~m_ship[r*COLS+kk];
      check("scan_mcol_a", 32'(m_col), 32'(1) << kk);
      check("scan_mline_a", 32'(m_line), 32'(el));
      tick();
      check("scan_mcol_b", 32'(m_col), 32'(1) << kk);
      check("scan_mline_b", 32'(m_line), 32'(el));
      tick();
    end
    tick();
    check("pre_rst_mcol", 32'(m_col), 2);
    #2;
    clr_n = 1'b0;
    #1;
    check("async_mcol", 32'(m_col), 1);
    check("async_mline", 32'(m_line), 32'h7f);
    check("async_hits", 32'(hits), 0);
    #2;
    clr_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
